// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth recoding for the radix-4 sequential MAC
// Contents:
//   booth_act_e   partial-product action selected by one radix-4 Booth digit
//   booth_state_e sequencer state encoding
//   booth_encode  maps a multiplier bit triplet {b[2i+1], b[2i], b[2i-1]} to an action
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_act_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  function automatic booth_act_e booth_encode(input logic [2:0] trip);
    booth_act_e act;
    case (trip)
      3'b001, 3'b010: act = POS1;
      3'b011:         act = POS2;
      3'b100:         act = NEG2;
      3'b101, 3'b110: act = NEG1;
      default:        act = ZERO;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - combinational radix-4 Booth partial-product selector
// Ports:
//   action  in   booth_act_e   digit action (ZERO, +A, +2A, -A, -2A)
//   a       in   WIDTH+2       multiplicand, already sign/zero-extended by the caller
//   pp      out  WIDTH+3       selected multiple, two's complement
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  booth_act_e         action,
  input  logic [WIDTH+1:0]   a,
  output logic [WIDTH+2:0]   pp
);

  // One extra bit over A so that 2A and -2A are representable without overflow.
  logic [WIDTH+2:0] a_ext;
  logic [WIDTH+2:0] a_dbl;

  assign a_ext = {a[WIDTH+1], a};
  assign a_dbl = {a, 1'b0};

  always_comb begin
    pp = '0;
    case (action)
      POS1:    pp = a_ext;
      POS2:    pp = a_dbl;
      NEG1:    pp = -a_ext;
      NEG2:    pp = -a_dbl;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mac.sv
// rtl/booth_r4_seq_mac.sv - sequential radix-4 Booth multiply-accumulate, result = a*b + c
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (accepted only in IDLE)
//   tc_mode              1 = a, b two's complement, 0 = unsigned
//   a, b                 multiplicand, multiplier (WIDTH)
//   c                    addend (2*WIDTH)
//   out_valid, out_ready result handshake
//   result               registered a*b + c, low 2*WIDTH bits
//   busy                 sequencer not idle
module booth_r4_seq_mac
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               tc_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int IW = $clog2(WIDTH/2 + 1);
  localparam int AW = WIDTH + 2;
  localparam int RW = 2 * WIDTH;

  booth_state_e   state_q, state_d;
  logic           tc_q;
  logic [AW-1:0]  a_q;
  // Multiplier with b[-1] appended at bit 0; shifted right two bits per digit
  // so the current triplet always sits in b_q[2:0].
  logic [AW:0]    b_q;
  logic [RW-1:0]  acc_q;
  logic [RW-1:0]  result_q;
  logic [IW-1:0]  idx_q;
  // Set once the last digit has been added; the following RUN cycle copies
  // acc into the result register and moves to DONE.
  logic           fin_q;

  logic [IW-1:0]  last_idx;
  booth_act_e     act;
  logic [AW:0]    pp;
  logic [RW-1:0]  pp_ext;
  logic [RW-1:0]  pp_sh;
  logic           accept;

  assign accept   = in_valid && (state_q == IDLE);
  // Unsigned operands need one extra digit to absorb the zero-extended top bits.
  assign last_idx = tc_q ? IW'(WIDTH/2 - 1) : IW'(WIDTH/2);
  assign act      = booth_encode(b_q[2:0]);

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .action (act),
    .a      (a_q),
    .pp     (pp)
  );

  assign pp_ext = {{(RW-AW-1){pp[AW]}}, pp};
  assign pp_sh  = pp_ext << {idx_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (fin_q)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      fin_q    <= 1'b0;
    end else if (accept) begin
      tc_q  <= tc_mode;
      a_q   <= {(tc_mode ? {2{a[WIDTH-1]}} : 2'b00), a};
      b_q   <= {(tc_mode ? {2{b[WIDTH-1]}} : 2'b00), b, 1'b0};
      acc_q <= c;
      idx_q <= '0;
      fin_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (fin_q) begin
        result_q <= acc_q;
      end else begin
        acc_q <= acc_q + pp_sh;
        b_q   <= b_q >> 2;
        idx_q <= idx_q + 1'b1;
        fin_q <= (idx_q == last_idx);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mac.sv
// tb/tb_booth_r4_seq_mac.sv - self-checking bench for booth_r4_seq_mac (WIDTH=8)
module tb_booth_r4_seq_mac;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           tc_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] c = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        t;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  booth_r4_seq_mac #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tc_mode   (tc_mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model: plain integer arithmetic on the interpreted operands.
  function automatic logic [15:0] ref_mac(input logic t, input logic [7:0] aa, input logic [7:0] bb,
                                          input logic [15:0] cc);
    int sa, sb, full;
    sa   = t ? int'($signed(aa)) : int'(aa);
    sb   = t ? int'($signed(bb)) : int'(bb);
    full = sa * sb + int'(cc);
    return full[15:0];
  endfunction

  // Cycles from the accept edge to out_valid: one per Booth digit plus the result register.
  function automatic int ref_lat(input logic t);
    return t ? (W/2 + 1) : (W/2 + 2);
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_op(input logic t, input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] cc,
                       input int bp, output logic [15:0] r, output int lat);
    int n;
    r   = '0;
    lat = 0;
    n   = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    tc_mode  = t;
    a        = aa;
    b        = bb;
    c        = cc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tc_mode  = 1'($urandom);
    a        = 8'($urandom);
    b        = 8'($urandom);
    c        = 16'($urandom);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    r = result;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_hold", {15'd0, out_valid, result}, {15'd0, 1'b1, r});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [15:0] r0;
    int          lat;
    int          n;

    vt[0] = '{1'b1, 8'h80, 8'h80, 16'h0000, 16'h4000, 5};
    vt[1] = '{1'b0, 8'hFF, 8'hFF, 16'h0000, 16'hFE01, 6};
    vt[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0000, 16'h0001, 5};
    vt[3] = '{1'b1, 8'h07, 8'hFD, 16'h0064, 16'h004F, 5};
    vt[4] = '{1'b0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFE00, 6};
    vt[5] = '{1'b1, 8'h7F, 8'h80, 16'h0000, 16'hC080, 5};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].t, vt[i].a, vt[i].b, vt[i].c, i % 3, r, lat);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // DONE held for 10 cycles with in_valid noise, then handshake with in_valid high
    tc_mode  = 1'b0;
    a        = 8'd12;
    b        = 8'd34;
    c        = 16'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    r0 = result;
    check("stall_result", 32'(r0), 32'(ref_mac(1'b0, 8'd12, 8'd34, 16'd5)));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      tc_mode  = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      c        = 16'($urandom);
      @(posedge clk);
      #1;
      check("stall_hold", {14'd0, out_valid, in_ready, result}, {14'd0, 1'b1, 1'b0, r0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tc_mode   = 1'b1;
    a         = 8'd3;
    b         = 8'd5;
    c         = 16'd0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_to_idle", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
    check("hs_result_held", 32'(result), 32'(r0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept_next_cycle", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("after_stall_result", 32'(result), 32'h000F);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset asserted mid-RUN at idx=2
    tc_mode  = 1'b0;
    a        = 8'hAB;
    b        = 8'hCD;
    c        = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_flags", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
    check("midrun_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b1, 8'd3, 8'd5, 16'd0, 0, r, lat);
    check("post_rst_result", 32'(r), 32'h000F);
    check("post_rst_latency", 32'(lat), 32'd5);

    // Random operations against the model, random backpressure
    for (int i = 0; i < 3000; i++) begin
      logic        t;
      logic [7:0]  ra, rb;
      logic [15:0] rc;
      t  = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 16'($urandom);
      do_op(t, ra, rb, rc, int'($urandom_range(0, 3)), r, lat);
      check("rand_result", 32'(r), 32'(ref_mac(t, ra, rb, rc)));
      check("rand_latency", 32'(lat), 32'(ref_lat(t)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
